// File: rtl/objective_pkg.sv
// objective_pkg: shared Q8.8 fixed-point types, constants and saturating narrowing for the neuron chain
package objective_pkg;
  localparam int FIX_W = 16;
  localparam int FRAC = 8;
  typedef logic signed [FIX_W-1:0] fix_t;
  typedef logic signed [FIX_W:0] wide_t;
  typedef logic [31:0] loss_t;
  // Clamp a W+1-bit intermediate back into W bits; overflow shows as the top two bits disagreeing.
  function automatic fix_t sat_fix(input wide_t v);
    return (v[FIX_W] == v[FIX_W-1]) ? fix_t'(v[FIX_W-1:0]) :
           (v[FIX_W] ? fix_t'({1'b1, {(FIX_W-1){1'b0}}}) : fix_t'({1'b0, {(FIX_W-1){1'b1}}}));
  endfunction
endpackage

// File: rtl/objective_loss.sv
// objective_loss: squares each sample's error, accumulates it with saturation and reports per-batch loss
// Ports: clock, reset (sync, active-high); add pulses once per sample with its diff;
// active marks the parent's loss state; last/done flag the closing sample before/after it is added;
// loss_valid/loss_data/loss_ready form the loss handshake.
module objective_loss import objective_pkg::*; #(
  parameter int F = FRAC,
  parameter int BATCH = 4
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  add,
  input  logic  active,
  input  fix_t  diff,
  input  logic  loss_ready,
  output logic  last,
  output logic  done,
  output logic  loss_valid,
  output loss_t loss_data
);
  localparam int CW = $clog2(BATCH + 1);
  logic [CW-1:0] cnt;
  logic signed [31:0] prod;
  loss_t acc, sq;
  logic [32:0] sum;
  assign prod = 32'(diff) * 32'(diff);
  assign sq = loss_t'(prod >>> F);
  assign sum = {1'b0, acc} + {1'b0, sq};
  assign last = cnt == CW'(BATCH - 1);
  assign done = cnt == CW'(BATCH);
  assign loss_valid = active;
  assign loss_data = acc;
  always_ff @(posedge clock)
    if (reset || (active && loss_ready)) begin
      cnt <= '0;
      acc <= '0;
    end else if (add) begin
      cnt <= cnt + CW'(1);
      acc <= sum[32] ? '1 : sum[31:0];
    end
endmodule

// File: rtl/objective.sv
// objective: pairs each result with a target and returns the saturated error target - result upstream
// Ports: clock, reset (sync, active-high); train selects error emission; result_*/target_* are
// valid/ready input streams; error_* returns the delta to the upstream neuron; loss_* reports
// batch squared-error loss when built with OBJECTIVE_LOSS_EN (tied off otherwise).
module objective import objective_pkg::*; #(
  parameter int W = FIX_W,
  parameter int F = FRAC,
  parameter int BATCH = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         train,
  input  logic         result_valid,
  input  logic [W-1:0] result_data,
  output logic         result_ready,
  input  logic         target_valid,
  input  logic [W-1:0] target_data,
  output logic         target_ready,
  output logic         error_valid,
  output logic [W-1:0] error_data,
  input  logic         error_ready,
  output logic         loss_valid,
  output logic [31:0]  loss_data,
  input  logic         loss_ready
);
  typedef enum logic [1:0] {
    LOAD,
    SUB,
    ERR
`ifdef OBJECTIVE_LOSS_EN
    , LOSS
`endif
  } state_t;
  state_t state, state_nx, after_sub, after_err;
  logic have_result, have_target, result_fire, target_fire;
  fix_t res_q, tgt_q, err_q, diff;
  assign result_ready = !reset && state == LOAD && !have_result;
  assign target_ready = !reset && state == LOAD && !have_target;
  assign result_fire = result_valid && result_ready;
  assign target_fire = target_valid && target_ready;
  assign diff = sat_fix(wide_t'(tgt_q) - wide_t'(res_q));
  assign error_valid = state == ERR;
  assign error_data = err_q;
`ifdef OBJECTIVE_LOSS_EN
  logic last, done;
  objective_loss #(.F(F), .BATCH(BATCH)) u_loss (
    .clock      (clock),
    .reset      (reset),
    .add        (state == SUB),
    .active     (state == LOSS),
    .diff       (diff),
    .loss_ready (loss_ready),
    .last       (last),
    .done       (done),
    .loss_valid (loss_valid),
    .loss_data  (loss_data)
  );
  // In SUB the counter still holds the pre-increment value; by ERR it has advanced.
  assign after_sub = last ? LOSS : LOAD;
  assign after_err = done ? LOSS : LOAD;
`else
  logic unused_loss;
  assign unused_loss = loss_ready | (F == BATCH);
  assign loss_valid = 1'b0;
  assign loss_data = '0;
  assign after_sub = LOAD;
  assign after_err = LOAD;
`endif
  always_comb begin
    state_nx = state;
    case (state)
      // Look through this cycle's handshakes so SUB follows the completing handshake directly.
      LOAD: state_nx = ((have_result || result_fire) && (have_target || target_fire)) ? SUB : LOAD;
      SUB: state_nx = train ? ERR : after_sub;
      ERR: state_nx = error_ready ? after_err : ERR;
`ifdef OBJECTIVE_LOSS_EN
      LOSS: state_nx = loss_ready ? LOAD : LOSS;
`endif
      default: state_nx = LOAD;
    endcase
  end
  always_ff @(posedge clock)
    if (reset) begin
      state <= LOAD;
      have_result <= 1'b0;
      have_target <= 1'b0;
      res_q <= '0;
      tgt_q <= '0;
      err_q <= '0;
    end else begin
      state <= state_nx;
      if (result_fire) begin
        res_q <= fix_t'(result_data);
        have_result <= 1'b1;
      end
      if (target_fire) begin
        tgt_q <= fix_t'(target_data);
        have_target <= 1'b1;
      end
      if (state == SUB) begin
        err_q <= diff;
        have_result <= 1'b0;
        have_target <= 1'b0;
      end
    end
endmodule
